// File: rtl/ctrl_seq.sv
// Stateful control decoder: opcode decode for reg_file/data memory controls,
// run/halt sequencing, multi-cycle load stalls and a saturating run-cycle counter.
module ctrl_seq #(
    parameter int unsigned               INSTR_W = 9,
    parameter int unsigned               OP_W    = 4,
    parameter int unsigned               MEM_LAT = 1,
    parameter logic [(2**OP_W)-1:0]      WR_MASK = 16'h3F3F,
    parameter logic [OP_W-1:0]           OP_LDI  = 4'b0100,
    parameter logic [OP_W-1:0]           OP_LDR  = 4'b0101,
    parameter logic [OP_W-1:0]           OP_STR  = 4'b0110,
    parameter logic [OP_W-1:0]           OP_BNZR = 4'b0111,
    parameter int unsigned               CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instruction,
    output logic [1:0]         RegLoadType,
    output logic               RegWrEn,
    output logic               StoreInst,
    output logic               OffsetSrc,
    output logic               Stall,
    output logic               Ack,
    output logic [CNT_W-1:0]   CycleCnt
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_INIT = (MEM_LAT > 0) ? WAIT_W'(MEM_LAT - 1) : '0;

    localparam logic [1:0] LT_MEM = 2'b00;
    localparam logic [1:0] LT_IMM = 2'b01;
    localparam logic [1:0] LT_ALU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [OP_W-1:0]    opcode;

    assign opcode = Instruction[INSTR_W-1 -: OP_W];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Decode outputs follow the current instruction directly while running.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        RegLoadType = LT_ALU;
        RegWrEn     = 1'b0;
        StoreInst   = 1'b0;
        OffsetSrc   = 1'b0;
        Stall       = 1'b1;
        Ack         = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = RUN;
            end
            RUN: begin
                if (Instruction == '1) begin
                    state_nxt = DONE;
                end else begin
                    Stall     = 1'b0;
                    OffsetSrc = (opcode == OP_BNZR);
                    StoreInst = (opcode == OP_STR);
                    RegWrEn   = WR_MASK[opcode];
                    if (opcode == OP_LDI) RegLoadType = LT_IMM;
                    if (opcode == OP_LDR) begin
                        RegLoadType = LT_MEM;
                        if (MEM_LAT > 0) begin
                            Stall     = 1'b1;
                            RegWrEn   = 1'b0;
                            state_nxt = WAIT;
                            wait_nxt  = WAIT_INIT;
                        end
                    end
                end
            end
            WAIT: begin
                RegLoadType = LT_MEM;
                if (wait_cnt != '0) begin
                    wait_nxt = wait_cnt - WAIT_W'(1);
                end else begin
                    Stall     = 1'b0;
                    RegWrEn   = 1'b1;
                    state_nxt = RUN;
                end
            end
            DONE: begin
                Ack = 1'b1;
                if (Start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run-cycle counter: cleared on an accepted Start, saturates instead of wrapping.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CycleCnt <= '0;
        end else if ((state == IDLE || state == DONE) && Start) begin
            CycleCnt <= '0;
        end else if ((state == RUN || state == WAIT) && CycleCnt != '1) begin
            CycleCnt <= CycleCnt + CNT_W'(1);
        end
    end

endmodule
